// File: rtl/bp_pkg.sv
// Shared constants and helpers for the BTB branch predictor.
package bp_pkg;

  localparam int ENTRIES  = 16;
  localparam int IDX_BITS = 4;
  localparam int TAG_BITS = 30 - IDX_BITS;

  // 2-bit saturating counter encodings; the MSB is the taken prediction.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam ctr_e CTR_RESET = WNT;
  localparam ctr_e CTR_ALLOC = WT;

  // Word-aligned index; pc[1:0] never participates.
  function automatic logic [IDX_BITS-1:0] pc_idx(input logic [31:0] pc);
    return pc[IDX_BITS+1:2];
  endfunction

  function automatic logic [TAG_BITS-1:0] pc_tag(input logic [31:0] pc);
    return pc[31:IDX_BITS+2];
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state function of a 2-bit saturating counter.
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       inc_i,
  output logic [1:0] ctr_o
);

  // Step up on taken, down on not-taken, holding at ST / SNT.
  always_comb begin
    ctr_o = ctr_i;
    if (inc_i) begin
      if (ctr_i != ST) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != SNT) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational lookup on the fetch
// PC, training and misprediction detection from the ALU-stage resolution.
module branch_predictor
  import bp_pkg::*;
(
  input  logic        clk_i,
  input  logic        rsn_i,
  input  logic        stall_core_i,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  output logic        bp_prediction_o,
  output logic        bp_taken_o,
  output logic [31:0] bp_pred_pc_o,
  input  logic        alu_valid_i,
  input  logic [31:0] alu_pc_i,
  input  logic        alu_branch_i,
  input  logic        alu_jumps_i,
  input  logic [31:0] alu_pc_jmp_i,
  input  logic        alu_pred_taken_i,
  input  logic [31:0] alu_pred_pc_i,
  output logic        bp_error_o
);

  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [TAG_BITS-1:0] tag_d    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [31:0]         target_d [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];
  logic [1:0]          ctr_d    [ENTRIES];

  logic [IDX_BITS-1:0] lk_idx, up_idx;
  logic [TAG_BITS-1:0] lk_tag, up_tag;
  logic                lk_hit, up_hit;
  logic                res, upd, act_taken;
  logic [1:0]          ctr_nxt;
  logic [3:0]          unused_pc_bits;

  assign lk_idx = pc_idx(pc_i);
  assign lk_tag = pc_tag(pc_i);
  assign up_idx = pc_idx(alu_pc_i);
  assign up_tag = pc_tag(alu_pc_i);
  assign unused_pc_bits = {pc_i[1:0], alu_pc_i[1:0]};

  // Fetch-side lookup reads the current table contents (pre-update).
  always_comb begin
    lk_hit          = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    bp_prediction_o = lk_hit;
    bp_taken_o      = lk_hit & ctr_q[lk_idx][1];
    bp_pred_pc_o    = lk_hit ? target_q[lk_idx] : 32'd0;
  end

  // Misprediction: wrong direction, or taken with the wrong target. Flush wins.
  always_comb begin
    res        = alu_valid_i & ~flush_i;
    upd        = res & ~stall_core_i;
    act_taken  = alu_branch_i & alu_jumps_i;
    up_hit     = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    bp_error_o = res & ((alu_pred_taken_i != act_taken) |
                        (act_taken & (alu_pred_pc_i != alu_pc_jmp_i)));
  end

  bp_sat_counter u_sat_counter (
    .ctr_i (ctr_q[up_idx]),
    .inc_i (alu_jumps_i),
    .ctr_o (ctr_nxt)
  );

  // Single write port: allocate, train or alias-invalidate the resolved entry.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (upd) begin
      if (alu_branch_i) begin
        if (up_hit) begin
          ctr_d[up_idx] = ctr_nxt;
          if (alu_jumps_i) target_d[up_idx] = alu_pc_jmp_i;
        end else if (alu_jumps_i) begin
          valid_d[up_idx]  = 1'b1;
          tag_d[up_idx]    = up_tag;
          target_d[up_idx] = alu_pc_jmp_i;
          ctr_d[up_idx]    = CTR_ALLOC;
        end
      end else if (up_hit) begin
        valid_d[up_idx] = 1'b0;
      end
    end
  end

  // Table storage; reset clears every entry to weakly not-taken.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_RESET;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;

  logic        clk_i = 1'b0;
  logic        rsn_i;
  logic        stall_core_i, flush_i;
  logic [31:0] pc_i;
  logic        bp_prediction_o, bp_taken_o;
  logic [31:0] bp_pred_pc_o;
  logic        alu_valid_i, alu_branch_i, alu_jumps_i, alu_pred_taken_i;
  logic [31:0] alu_pc_i, alu_pc_jmp_i, alu_pred_pc_i;
  logic        bp_error_o;

  int tests_run = 0;
  int tests_failed = 0;

  branch_predictor dut (
    .clk_i           (clk_i),
    .rsn_i           (rsn_i),
    .stall_core_i    (stall_core_i),
    .flush_i         (flush_i),
    .pc_i            (pc_i),
    .bp_prediction_o (bp_prediction_o),
    .bp_taken_o      (bp_taken_o),
    .bp_pred_pc_o    (bp_pred_pc_o),
    .alu_valid_i     (alu_valid_i),
    .alu_pc_i        (alu_pc_i),
    .alu_branch_i    (alu_branch_i),
    .alu_jumps_i     (alu_jumps_i),
    .alu_pc_jmp_i    (alu_pc_jmp_i),
    .alu_pred_taken_i(alu_pred_taken_i),
    .alu_pred_pc_i   (alu_pred_pc_i),
    .bp_error_o      (bp_error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic br, input logic jmp,
                         input logic [31:0] tgt, input logic pt, input logic [31:0] ppc);
    alu_valid_i      = 1'b1;
    alu_pc_i         = pc;
    alu_branch_i     = br;
    alu_jumps_i      = jmp;
    alu_pc_jmp_i     = tgt;
    alu_pred_taken_i = pt;
    alu_pred_pc_i    = ppc;
    #1;
  endtask

  task automatic idle_alu();
    alu_valid_i      = 1'b0;
    alu_branch_i     = 1'b0;
    alu_jumps_i      = 1'b0;
    alu_pred_taken_i = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    pc_i = pc;
    #1;
  endtask

  initial begin
    rsn_i = 1'b0; stall_core_i = 1'b0; flush_i = 1'b0; pc_i = 32'h1000;
    alu_pc_i = '0; alu_pc_jmp_i = '0; alu_pred_pc_i = '0;
    idle_alu();
    #12;
    chk("rst_pred",   bp_prediction_o, 0);
    chk("rst_taken",  bp_taken_o, 0);
    chk("rst_predpc", bp_pred_pc_o, 0);
    chk("rst_err",    bp_error_o, 0);
    rsn_i = 1'b1;
    tick();

    // Miss + taken: error, allocate; same-cycle lookup sees old contents.
    look(32'h1008);
    resolve(32'h1008, 1, 1, 32'h1040, 0, 32'h0);
    chk("alloc_err",      bp_error_o, 1);
    chk("alloc_pre_pred", bp_prediction_o, 0);
    tick(); idle_alu(); #1;
    chk("alloc_pred",   bp_prediction_o, 1);
    chk("alloc_taken",  bp_taken_o, 1);
    chk("alloc_predpc", bp_pred_pc_o, 32'h1040);
    look(32'h100B);
    chk("lowbits_ignored", bp_pred_pc_o, 32'h1040);
    look(32'h1008);

    // Three not-taken: 10 -> 01 -> 00 -> 00.
    resolve(32'h1008, 1, 0, 32'h1040, 1, 32'h1040);
    chk("nt1_err", bp_error_o, 1);
    tick(); #1;
    chk("nt1_taken", bp_taken_o, 0);
    chk("nt1_pred",  bp_prediction_o, 1);
    resolve(32'h1008, 1, 0, 32'h1040, 0, 32'h1040);
    chk("nt2_err", bp_error_o, 0);
    tick(); #1;
    chk("nt2_taken", bp_taken_o, 0);
    resolve(32'h1008, 1, 0, 32'h1040, 0, 32'h1040);
    chk("nt3_err", bp_error_o, 0);
    tick(); #1;
    chk("nt3_taken", bp_taken_o, 0);

    // Climb back: 00 -> 01 (still not taken) -> 10.
    resolve(32'h1008, 1, 1, 32'h1040, 0, 32'h0);
    chk("up1_err", bp_error_o, 1);
    tick(); #1;
    chk("up1_taken", bp_taken_o, 0);
    resolve(32'h1008, 1, 1, 32'h1040, 0, 32'h0);
    tick(); #1;
    chk("up2_taken", bp_taken_o, 1);

    // Right direction, wrong target: error and retarget; ctr 10 -> 11.
    resolve(32'h1008, 1, 1, 32'h1080, 1, 32'h1040);
    chk("tgt_err", bp_error_o, 1);
    tick(); #1;
    chk("tgt_predpc", bp_pred_pc_o, 32'h1080);
    resolve(32'h1008, 1, 1, 32'h1080, 1, 32'h1080);
    chk("correct_err", bp_error_o, 0);
    tick(); #1;

    // 11 -> 10 normally, then a stalled not-taken held 3 cycles.
    resolve(32'h1008, 1, 0, 32'h1080, 1, 32'h1080);
    tick(); #1;
    chk("pre_stall_taken", bp_taken_o, 1);
    stall_core_i = 1'b1;
    #1;
    chk("stall_err", bp_error_o, 1);
    tick(); tick(); tick(); #1;
    chk("stall_held_taken", bp_taken_o, 1);
    stall_core_i = 1'b0;
    tick(); #1;
    chk("stall_release_taken", bp_taken_o, 0);
    // One step only (01): a single taken brings it back to 10.
    resolve(32'h1008, 1, 1, 32'h1080, 0, 32'h0);
    tick(); #1;
    chk("stall_once_taken", bp_taken_o, 1);

    // Flush suppresses error and update.
    flush_i = 1'b1;
    resolve(32'h1008, 1, 0, 32'h2222, 1, 32'h1080);
    chk("flush_err", bp_error_o, 0);
    tick(); #1;
    flush_i = 1'b0;
    idle_alu(); #1;
    chk("flush_taken",  bp_taken_o, 1);
    chk("flush_predpc", bp_pred_pc_o, 32'h1080);

    // Not-taken miss writes nothing; un-predicted non-branch is no error.
    resolve(32'h1100, 1, 0, 32'h1200, 0, 32'h0);
    chk("ntmiss_err", bp_error_o, 0);
    tick(); look(32'h1100);
    chk("ntmiss_pred", bp_prediction_o, 0);
    resolve(32'h1104, 0, 0, 32'h0, 0, 32'h0);
    chk("nonbr_err", bp_error_o, 0);
    tick();

    // Alias 0x1048 shares index 2 with 0x1008: replace, then invalidate.
    resolve(32'h1048, 1, 1, 32'h2000, 0, 32'h0);
    tick(); idle_alu(); look(32'h1008);
    chk("alias_old_pred", bp_prediction_o, 0);
    look(32'h1048);
    chk("alias_new_predpc", bp_pred_pc_o, 32'h2000);
    resolve(32'h1048, 0, 0, 32'h0, 1, 32'h2000);
    chk("alias_inv_err", bp_error_o, 1);
    tick(); idle_alu(); #1;
    chk("alias_inv_pred",   bp_prediction_o, 0);
    chk("alias_inv_predpc", bp_pred_pc_o, 0);

    // Asynchronous reset mid-operation wipes the table immediately.
    resolve(32'h1010, 1, 1, 32'h3000, 0, 32'h0);
    tick(); idle_alu(); look(32'h1010);
    chk("pre_rst_pred", bp_prediction_o, 1);
    #2 rsn_i = 1'b0;
    #1;
    chk("async_rst_pred",   bp_prediction_o, 0);
    chk("async_rst_predpc", bp_pred_pc_o, 0);
    rsn_i = 1'b1;
    tick(); #1;
    chk("post_rst_pred", bp_prediction_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor directly upstream of the fetch stage. It supplies the taken/target prediction that fetch uses to pick its next PC.
- Structure: direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- Lookup is combinational on the current fetch PC.
- Training and misprediction detection use the ALU-stage resolution, with prediction metadata carried down the pipeline.
- Produces bp_error_o, which makes fetch redirect to the ALU-computed PC.

Parameters:
- ENTRIES, 16, number of BTB entries (power of 2).
- IDX_BITS, 4, log2(ENTRIES); index = pc[IDX_BITS+1:2].
- TAG_BITS, 26, 30-IDX_BITS; tag = pc[31:IDX_BITS+2].

Ports:
- clk_i  in  1  clock, rising edge.
- rsn_i  in  1  reset, asynchronous, active-low.
- stall_core_i  in  1  pipeline stall; blocks table updates.
- flush_i  in  1  exception/iret in progress; suppresses error and update.
- pc_i  in  32  current fetch PC (lookup address).
- bp_prediction_o  out  1  BTB hit for pc_i.
- bp_taken_o  out  1  predicted taken (counter MSB, gated by hit).
- bp_pred_pc_o  out  32  predicted target (0 when no hit).
- alu_valid_i  in  1  ALU stage holds a valid instruction this cycle.
- alu_pc_i  in  32  PC of the instruction in ALU.
- alu_branch_i  in  1  instruction is a branch/jump.
- alu_jumps_i  in  1  branch resolved taken.
- alu_pc_jmp_i  in  32  resolved taken target.
- alu_pred_taken_i  in  1  bp_prediction_o & bp_taken_o captured at fetch, piped to ALU.
- alu_pred_pc_i  in  32  bp_pred_pc_o captured at fetch, piped to ALU.
- bp_error_o  out  1  misprediction; fetch redirects this cycle.

Behaviour:
- Storage per entry:
  - valid (1 bit), tag (TAG_BITS), target (32), ctr (2 bits).
  - All held in flops, no SRAM.
- Reset (rsn_i low, async):
  - All valid=0, ctr=01 (weakly not-taken), tag/target=0.
  - Outputs become bp_prediction_o=0, bp_taken_o=0, bp_pred_pc_o=0, bp_error_o=0.
- Lookup (combinational, zero latency):
  - hit = valid[idx] & tag[idx]==tag(pc_i).
  - bp_prediction_o = hit.
  - bp_taken_o = hit & ctr[idx][1].
  - bp_pred_pc_o = hit ? target[idx] : 0.
- Error (combinational):
  - Let res = alu_valid_i & !flush_i; act_taken = alu_branch_i & alu_jumps_i.
  - bp_error_o = res & ((alu_pred_taken_i != act_taken) | (act_taken & alu_pred_pc_i != alu_pc_jmp_i)).
  - A non-branch that was predicted taken (alias) is an error; fetch falls to alu_pc_no_jmp.
- Update (registered, single write per cycle):
  - Enabled when upd = res & !stall_core_i. Index and tag come from alu_pc_i.
  - Branch, miss, taken: allocate with valid=1, tag, target=alu_pc_jmp_i, ctr=10.
  - Branch, miss, not taken: no write.
  - Branch, hit: ctr saturating +1 if taken, -1 if not taken (00 and 11 saturate); target<=alu_pc_jmp_i if taken.
  - Non-branch, hit: valid<=0 (alias invalidation).
- Simultaneous lookup and update on the same index:
  - Lookup returns pre-update contents.
  - The new value is visible from the next cycle.
- Stall held: no update. The same ALU instruction updates exactly once, on the cycle stall deasserts.
- Flush has priority over resolution: no error, no update that cycle. The table is not cleared.
- Reset mid-operation: all state lost immediately (asynchronous); lookups miss until retrained.
- Bits pc[1:0] are ignored throughout.

Decomposition:
- Package bp_pkg holds:
  - Counter encodings: SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - CTR_RESET=WNT, CTR_ALLOC=WT.
  - Index/tag extraction widths.
- One sub-module, bp_sat_counter: 2-bit saturating inc/dec next-state function. It is instantiated per update path, not per entry.

Test Plan:
- Reset, then pc_i=0x1000 -> bp_prediction_o=0, bp_taken_o=0, bp_pred_pc_o=0, bp_error_o=0.
- ALU resolves a taken branch at 0x1008 to 0x1040 with alu_pred_taken_i=0 -> bp_error_o=1 that cycle. Next cycle pc_i=0x1008 -> prediction=1, taken=1, pred_pc=0x1040.
- Same branch resolved not-taken three times -> ctr goes 10→01→00→00 (saturates). bp_taken_o=0 from the first not-taken onward. bp_error_o=1 only on the first (pred taken) resolution.
- Hit with taken and alu_pred_pc_i=0x1040 but alu_pc_jmp_i=0x1080 -> bp_error_o=1. Next lookup of the same PC returns target 0x1080.
- Resolution held with stall_core_i=1 for 3 cycles, then released -> counter changes by exactly one step.
- Resolution with flush_i=1 and mismatching prediction -> bp_error_o=0, table unchanged. Alias at 0x1048 (same index as 0x1008, different tag) as a non-branch with hit -> entry invalidated.
